// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vending controller and the coin dispenser.
// The controller side is the master; the dispenser side is the slave.
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       refill;
  logic       busy;
  logic       done;
  logic       short;
  logic       coin5;
  logic       coin2;
  logic       coin1;
  logic [7:0] remaining;
  logic [7:0] stock5;
  logic [7:0] stock2;
  logic [7:0] stock1;

  modport master (
    output start, amount, refill,
    input  busy, done, short, coin5, coin2, coin1,
    input  remaining, stock5, stock2, stock1
  );

  modport slave (
    input  start, amount, refill,
    output busy, done, short, coin5, coin2, coin1,
    output remaining, stock5, stock2, stock1
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: ejects 5/2/1 zl coins as timed pulses while tracking coin stock.
// Every output comes straight from a flop; reset abandons any payout and reloads the stock.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter logic [7:0]  STOCK5       = 8'd10,
  parameter logic [7:0]  STOCK2       = 8'd10,
  parameter logic [7:0]  STOCK1       = 8'd10
) (
  input logic                clk,
  input logic                reset,
  change_dispenser_if.slave  dif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] stk5_q, stk5_d;
  logic [7:0] stk2_q, stk2_d;
  logic [7:0] stk1_q, stk1_d;
  logic       coin5_q, coin5_d;
  logic       coin2_q, coin2_d;
  logic       coin1_q, coin1_d;
  logic       done_q, done_d;
  logic       short_q, short_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rem_q   <= 8'd0;
      stk5_q  <= STOCK5;
      stk2_q  <= STOCK2;
      stk1_q  <= STOCK1;
      coin5_q <= 1'b0;
      coin2_q <= 1'b0;
      coin1_q <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      stk5_q  <= stk5_d;
      stk2_q  <= stk2_d;
      stk1_q  <= stk1_d;
      coin5_q <= coin5_d;
      coin2_q <= coin2_d;
      coin1_q <= coin1_d;
      done_q  <= done_d;
      short_q <= short_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    stk5_d  = stk5_q;
    stk2_d  = stk2_q;
    stk1_d  = stk1_q;
    coin5_d = coin5_q;
    coin2_d = coin2_q;
    coin1_d = coin1_q;
    done_d  = 1'b0;
    short_d = short_q;

    case (state_q)
      S_IDLE: begin
        if (dif.start) begin
          rem_d   = dif.amount;
          short_d = 1'b0;
          state_d = S_SELECT;
        end else if (dif.refill) begin
          stk5_d = STOCK5;
          stk2_d = STOCK2;
          stk1_d = STOCK1;
        end
      end
      S_SELECT: begin
        // Largest coin that fits and is in stock wins; the >= guards keep remaining from wrapping.
        if (rem_q >= 8'd5 && stk5_q != 8'd0) begin
          coin5_d = 1'b1;
          rem_d   = rem_q - 8'd5;
          stk5_d  = stk5_q - 8'd1;
          cnt_d   = PULSE_LD;
          state_d = S_PULSE;
        end else if (rem_q >= 8'd2 && stk2_q != 8'd0) begin
          coin2_d = 1'b1;
          rem_d   = rem_q - 8'd2;
          stk2_d  = stk2_q - 8'd1;
          cnt_d   = PULSE_LD;
          state_d = S_PULSE;
        end else if (rem_q >= 8'd1 && stk1_q != 8'd0) begin
          coin1_d = 1'b1;
          rem_d   = rem_q - 8'd1;
          stk1_d  = stk1_q - 8'd1;
          cnt_d   = PULSE_LD;
          state_d = S_PULSE;
        end else begin
          short_d = (rem_q != 8'd0);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          coin5_d = 1'b0;
          coin2_d = 1'b0;
          coin1_d = 1'b0;
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign dif.busy      = busy_q;
  assign dif.done      = done_q;
  assign dif.short     = short_q;
  assign dif.coin5     = coin5_q;
  assign dif.coin2     = coin2_q;
  assign dif.coin1     = coin1_q;
  assign dif.remaining = rem_q;
  assign dif.stock5    = stk5_q;
  assign dif.stock2    = stk2_q;
  assign dif.stock1    = stk1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout sequences, pulse timing, shortfall,
// ignored starts while busy, and reset in the middle of a payout.
module tb_change_dispenser;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   coin_seq[$];
  int   hi_w[$];
  int   lo_w[$];
  int   done_edge;
  int   busy_edge;
  int   ndone;
  int   overlap;

  change_dispenser_if dif();

  change_dispenser #(
    .PULSE_CYCLES(4),
    .GAP_CYCLES  (4),
    .STOCK5      (8'd10),
    .STOCK2      (8'd10),
    .STOCK1      (8'd10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dif  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic do_refill();
    @(negedge clk);
    dif.refill = 1'b1;
    @(negedge clk);
    dif.refill = 1'b0;
  endtask

  // Issues one start and records coin pulses until busy drops or the budget runs out.
  // inj >= 0 raises start (amount 9) for one cycle at that cycle index while busy.
  task automatic pay(input logic [7:0] amt, input int budget, input int inj);
    int   hi_cnt;
    int   lo_cnt;
    logic prev_any;
    logic any;
    logic seen;
    coin_seq.delete();
    hi_w.delete();
    lo_w.delete();
    done_edge = -1;
    busy_edge = -1;
    ndone     = 0;
    overlap   = 0;
    hi_cnt    = 0;
    lo_cnt    = 0;
    prev_any  = 1'b0;
    seen      = 1'b0;
    @(negedge clk);
    dif.start  = 1'b1;
    dif.amount = amt;
    @(negedge clk);
    dif.start  = 1'b0;
    dif.amount = 8'd0;
    chk("busy_after_start", int'(dif.busy), 1);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == inj) begin
        dif.start  = 1'b1;
        dif.amount = 8'd9;
      end else if (k == inj + 1) begin
        dif.start  = 1'b0;
        dif.amount = 8'd0;
      end
      any = dif.coin5 | dif.coin2 | dif.coin1;
      if ((int'(dif.coin5) + int'(dif.coin2) + int'(dif.coin1)) > 1) overlap++;
      if (any && !prev_any) begin
        if (seen) lo_w.push_back(lo_cnt);
        coin_seq.push_back(dif.coin5 ? 5 : (dif.coin2 ? 2 : 1));
        hi_cnt = 0;
        seen   = 1'b1;
      end
      if (!any && prev_any) begin
        hi_w.push_back(hi_cnt);
        lo_cnt = 0;
      end
      if (any) hi_cnt++;
      else     lo_cnt++;
      prev_any = any;
      if (dif.done) begin
        ndone++;
        if (done_edge < 0) done_edge = k;
      end
      if (!dif.busy) begin
        busy_edge = k;
        break;
      end
    end
    if (busy_edge < 0) chk("payout_timeout", 0, 1);
  endtask

  initial begin
    int ok_cnt;
    int done_seen;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    dif.start  = 1'b0;
    dif.amount = 8'd0;
    dif.refill = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   int'(dif.busy), 0);
    chk("rst_done",   int'(dif.done), 0);
    chk("rst_short",  int'(dif.short), 0);
    chk("rst_coins",  int'({dif.coin5, dif.coin2, dif.coin1}), 0);
    chk("rst_rem",    int'(dif.remaining), 0);
    chk("rst_stock5", int'(dif.stock5), 10);
    chk("rst_stock2", int'(dif.stock2), 10);
    chk("rst_stock1", int'(dif.stock1), 10);
    reset = 1'b0;

    // amount 12: 5, 5, 2
    pay(8'd12, 60, -1);
    chk("a12_ncoins", coin_seq.size(), 3);
    if (coin_seq.size() == 3) begin
      chk("a12_c0", coin_seq[0], 5);
      chk("a12_c1", coin_seq[1], 5);
      chk("a12_c2", coin_seq[2], 2);
    end
    chk("a12_nhi", hi_w.size(), 3);
    foreach (hi_w[i]) chk("a12_pulse_w", hi_w[i], 4);
    chk("a12_nlo", lo_w.size(), 2);
    foreach (lo_w[i]) chk("a12_gap_w", lo_w[i], 5);
    chk("a12_done_edge", done_edge, 28);
    chk("a12_busy_edge", busy_edge, 29);
    chk("a12_ndone", ndone, 1);
    chk("a12_overlap", overlap, 0);
    chk("a12_short", int'(dif.short), 0);
    chk("a12_rem", int'(dif.remaining), 0);
    chk("a12_stock5", int'(dif.stock5), 8);
    chk("a12_stock2", int'(dif.stock2), 9);
    chk("a12_stock1", int'(dif.stock1), 10);

    // amount 0: straight to done
    pay(8'd0, 10, -1);
    chk("a0_ncoins", coin_seq.size(), 0);
    chk("a0_done_edge", done_edge, 1);
    chk("a0_busy_edge", busy_edge, 2);
    chk("a0_short", int'(dif.short), 0);

    // drain 1 zl coins, then 3 ends short with one 2 zl coin
    do_refill();
    chk("refill_stock5", int'(dif.stock5), 10);
    ok_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      pay(8'd1, 20, -1);
      if (coin_seq.size() == 1 && coin_seq[0] == 1 && done_edge == 10) ok_cnt++;
    end
    chk("drain_ok", ok_cnt, 10);
    chk("drain_stock1", int'(dif.stock1), 0);
    pay(8'd3, 30, -1);
    chk("a3_ncoins", coin_seq.size(), 1);
    if (coin_seq.size() == 1) chk("a3_c0", coin_seq[0], 2);
    chk("a3_done_edge", done_edge, 10);
    chk("a3_short", int'(dif.short), 1);
    chk("a3_rem", int'(dif.remaining), 1);
    chk("a3_stock2", int'(dif.stock2), 9);

    // empty the 5 zl stock, then 7 pays 2, 2, 2, 1
    do_refill();
    pay(8'd50, 120, -1);
    chk("a50_ncoins", coin_seq.size(), 10);
    chk("a50_stock5", int'(dif.stock5), 0);
    chk("a50_short", int'(dif.short), 0);
    pay(8'd7, 60, -1);
    chk("a7_ncoins", coin_seq.size(), 4);
    if (coin_seq.size() == 4) begin
      chk("a7_c0", coin_seq[0], 2);
      chk("a7_c1", coin_seq[1], 2);
      chk("a7_c2", coin_seq[2], 2);
      chk("a7_c3", coin_seq[3], 1);
    end
    chk("a7_done_edge", done_edge, 37);
    chk("a7_rem", int'(dif.remaining), 0);
    chk("a7_short", int'(dif.short), 0);
    chk("a7_stock2", int'(dif.stock2), 7);
    chk("a7_stock1", int'(dif.stock1), 9);

    // start while busy is ignored
    do_refill();
    pay(8'd6, 40, 3);
    chk("busy_ncoins", coin_seq.size(), 2);
    if (coin_seq.size() == 2) begin
      chk("busy_c0", coin_seq[0], 5);
      chk("busy_c1", coin_seq[1], 1);
    end
    chk("busy_ndone", ndone, 1);
    chk("busy_done_edge", done_edge, 19);
    chk("busy_rem", int'(dif.remaining), 0);
    chk("busy_stock5", int'(dif.stock5), 9);
    chk("busy_stock1", int'(dif.stock1), 9);
    repeat (25) @(negedge clk);
    chk("busy_no_restart", int'(dif.busy), 0);

    // reset during the second coin's pulse
    do_refill();
    @(negedge clk);
    dif.start  = 1'b1;
    dif.amount = 8'd12;
    @(negedge clk);
    dif.start  = 1'b0;
    dif.amount = 8'd0;
    repeat (11) @(negedge clk);
    chk("mid_coin5", int'(dif.coin5), 1);
    chk("mid_stock5", int'(dif.stock5), 8);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_coin5", int'(dif.coin5), 0);
    chk("rstmid_busy", int'(dif.busy), 0);
    chk("rstmid_rem", int'(dif.remaining), 0);
    chk("rstmid_stock5", int'(dif.stock5), 10);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dif.done || dif.coin5 || dif.coin2 || dif.coin1) done_seen++;
    end
    chk("rstmid_quiet", done_seen, 0);
    do_refill();
    pay(8'd3, 40, -1);
    chk("post_ncoins", coin_seq.size(), 2);
    if (coin_seq.size() == 2) begin
      chk("post_c0", coin_seq[0], 2);
      chk("post_c1", coin_seq[1], 1);
    end
    chk("post_done_edge", done_edge, 19);
    chk("post_short", int'(dif.short), 0);
    chk("post_stock2", int'(dif.stock2), 9);
    chk("post_stock1", int'(dif.stock1), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
